// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory: in-order drain over
// a req/ack port, store-to-load forwarding from the youngest matching entry, FENCE drain.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    input  logic [XLEN-1:0]          st_addr,
    input  logic [XLEN-1:0]          st_data,
    input  logic [3:0]               st_be,
    output logic                     st_stall,
    input  logic                     ld_valid,
    input  logic [XLEN-1:0]          ld_addr,
    input  logic [3:0]               ld_be,
    output logic                     ld_hit,
    output logic [XLEN-1:0]          ld_data,
    output logic                     ld_conflict,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic                     mem_req,
    output logic [XLEN-1:0]          mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FENCE = 1'b1;

    logic [DEPTH-1:0] ent_valid_q;
    logic [XLEN-3:0]  ent_addr_q [DEPTH];
    logic [XLEN-1:0]  ent_data_q [DEPTH];
    logic [3:0]       ent_be_q   [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [PW:0]      count_q;
    logic [0:0]       state_q, state_d;

    logic enq, deq;
    logic ld_match;
    logic [3:0]      young_be;
    logic [XLEN-1:0] young_data;
    logic [PW-1:0]   scan_idx;

    // Byte offsets never matter: lookups and memory writes are word granular.
    logic unused_lsbs;
    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // Stall is a function of registered state only; a same-cycle ack does not free a slot.
    assign st_stall = st_valid && ((count_q == (PW+1)'(DEPTH)) || (state_q == ST_FENCE));
    assign enq      = st_valid && !st_stall;
    assign mem_req  = (count_q != '0);
    assign deq      = mem_req && mem_ack;

    assign mem_addr  = mem_req ? {ent_addr_q[head_q], 2'b00} : '0;
    assign mem_wdata = mem_req ? ent_data_q[head_q] : '0;
    assign mem_be    = mem_req ? ent_be_q[head_q] : '0;
    assign count     = count_q;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        ld_match   = 1'b0;
        young_be   = '0;
        young_data = '0;
        scan_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (ent_valid_q[scan_idx] &&
                (ent_addr_q[scan_idx] == ld_addr[XLEN-1:2]) &&
                ((ent_be_q[scan_idx] & ld_be) != 4'b0000)) begin
                ld_match   = 1'b1;
                young_be   = ent_be_q[scan_idx];
                young_data = ent_data_q[scan_idx];
            end
        end
    end

    assign ld_hit      = ld_valid && ld_match && ((young_be & ld_be) == ld_be);
    assign ld_conflict = ld_valid && ld_match && !ld_hit;
    assign ld_data     = (ld_valid && ld_match) ? young_data : '0;

    assign fence_done = (state_q == ST_FENCE) && (count_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (fence_req) state_d = ST_FENCE;
            ST_FENCE: if (count_q == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
                ent_be_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= ST_RUN;
        end else begin
            // Enqueue and dequeue never target the same slot: full blocks enqueue.
            if (deq) begin
                ent_valid_q[head_q] <= 1'b0;
                head_q              <= head_q + PW'(1);
            end
            if (enq) begin
                ent_valid_q[tail_q] <= 1'b1;
                ent_addr_q[tail_q]  <= st_addr[XLEN-1:2];
                ent_data_q[tail_q]  <= st_data;
                ent_be_q[tail_q]    <= st_be;
                tail_q              <= tail_q + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer with a queue-based reference model
// and a scoreboard monitor that checks every retired memory write.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, ld_valid, fence_req, mem_ack;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [3:0]  st_be, ld_be;
    logic        st_stall, ld_hit, ld_conflict, fence_done, mem_req;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [2:0]  count;

    ent_t mb[$];
    ent_t sbq[$];
    ent_t mon_e;
    bit   mfence;
    int   tests = 0;
    int   fails = 0;
    int   pulses;

    store_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_stall(st_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .fence_req(fence_req), .fence_done(fence_done),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) assert (!(st_valid && ld_valid)) else $error("store and load together");

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted memory write must match the oldest expected store.
    always @(negedge clk) begin
        if (reset && mem_req && mem_ack) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL drain_underflow: got write 0x%08h expected none", mem_addr);
            end else begin
                mon_e = sbq.pop_front();
                chk("drain_addr", mem_addr, {mon_e.addr[31:2], 2'b00});
                chk("drain_data", mem_wdata, mon_e.data);
                chk("drain_be", {28'h0, mem_be}, {28'h0, mon_e.be});
            end
        end
    end

    // One clock of the reference model: check outputs at negedge, update state at posedge.
    task automatic cycle();
        bit          m_stall, m_match, m_hit, m_conf, do_enq, do_deq, nf;
        logic [3:0]  yb;
        logic [31:0] yd;
        ent_t        e;
        @(negedge clk);
        m_stall = st_valid && (mb.size() == DEPTH || mfence);
        m_match = 0;
        yb = '0;
        yd = '0;
        for (int i = mb.size() - 1; i >= 0; i--) begin
            if (!m_match && mb[i].addr[31:2] == ld_addr[31:2] && (mb[i].be & ld_be) != 0) begin
                m_match = 1;
                yb = mb[i].be;
                yd = mb[i].data;
            end
        end
        m_hit  = ld_valid && m_match && ((yb & ld_be) == ld_be);
        m_conf = ld_valid && m_match && !m_hit;
        chk("st_stall", {31'h0, st_stall}, {31'h0, m_stall});
        chk("ld_hit", {31'h0, ld_hit}, {31'h0, m_hit});
        chk("ld_conflict", {31'h0, ld_conflict}, {31'h0, m_conf});
        if (m_hit) chk("ld_data", ld_data, yd);
        chk("count", {29'h0, count}, mb.size());
        chk("mem_req", {31'h0, mem_req}, {31'h0, mb.size() != 0});
        chk("fence_done", {31'h0, fence_done}, {31'h0, mfence && mb.size() == 0});
        do_enq = st_valid && !m_stall;
        do_deq = mb.size() != 0 && mem_ack;
        nf = mfence;
        if (!mfence && fence_req) nf = 1;
        else if (mfence && mb.size() == 0) nf = 0;
        e.addr = st_addr;
        e.data = st_data;
        e.be   = st_be;
        @(posedge clk);
        if (do_deq) void'(mb.pop_front());
        if (do_enq) begin
            mb.push_back(e);
            sbq.push_back(e);
        end
        mfence = nf;
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        cycle();
        st_valid = 1'b0;
    endtask

    task automatic drain();
        mem_ack = 1'b1;
        repeat (DEPTH + 2) cycle();
        mem_ack = 1'b0;
        chk("drain_count", {29'h0, count}, 32'd0);
        chk("drain_sb_empty", sbq.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        st_valid = 0; ld_valid = 0; fence_req = 0; mem_ack = 0;
        st_addr = 0; st_data = 0; st_be = 0; ld_addr = 0; ld_be = 0;
        mfence = 0;
        #1;
        chk("rst_count", {29'h0, count}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_fence_done", {31'h0, fence_done}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Held head write under no ack
        store(32'h100, 32'hDEADBEEF, 4'hF);
        for (int k = 0; k < 5; k++) begin
            chk("t1_req", {31'h0, mem_req}, 32'd1);
            chk("t1_addr", mem_addr, 32'h100);
            chk("t1_data", mem_wdata, 32'hDEADBEEF);
            chk("t1_be", {28'h0, mem_be}, 32'hF);
            cycle();
        end
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        chk("t1_count", {29'h0, count}, 32'd0);

        // Fill, stall on full, drain across pointer wrap
        for (int k = 0; k < 4; k++) store(32'h400 + 32'(k) * 4, 32'hA000_0000 + 32'(k), 4'hF);
        chk("t2_full", {29'h0, count}, 32'd4);
        st_valid = 1'b1; st_addr = 32'h410; st_data = 32'hA000_0004; st_be = 4'hF;
        #1;
        chk("t2_stall", {31'h0, st_stall}, 32'd1);
        cycle();
        cycle();
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        chk("t2_unstall", {31'h0, st_stall}, 32'd0);
        cycle();
        st_valid = 1'b0;
        drain();

        // Youngest-match forwarding
        store(32'h200, 32'h11111111, 4'hF);
        store(32'h200, 32'h22222222, 4'hF);
        ld_valid = 1'b1; ld_addr = 32'h200; ld_be = 4'hF;
        #1;
        chk("t3_hit", {31'h0, ld_hit}, 32'd1);
        chk("t3_data", ld_data, 32'h22222222);
        cycle();
        ld_valid = 1'b0;
        drain();

        // Partial overlap vs exact byte hit
        store(32'h301, 32'h0000AB00, 4'b0010);
        ld_valid = 1'b1; ld_addr = 32'h300; ld_be = 4'hF;
        #1;
        chk("t4_conflict", {31'h0, ld_conflict}, 32'd1);
        chk("t4_nohit", {31'h0, ld_hit}, 32'd0);
        cycle();
        ld_addr = 32'h301; ld_be = 4'b0010;
        #1;
        chk("t4_byte_hit", {31'h0, ld_hit}, 32'd1);
        chk("t4_byte_data", ld_data, 32'h0000AB00);
        cycle();
        ld_valid = 1'b0;
        drain();

        // Fence drain with ack every other cycle
        for (int k = 0; k < 3; k++) store(32'h800 + 32'(k) * 4, 32'hF000_0000 + 32'(k), 4'hF);
        fence_req = 1'b1;
        cycle();
        fence_req = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            st_valid = (k == 0); st_addr = 32'h900; st_data = 32'h5; st_be = 4'hF;
            mem_ack = k[0];
            #1;
            if (k == 0) chk("t5_stall", {31'h0, st_stall}, 32'd1);
            if (fence_done) pulses++;
            cycle();
        end
        st_valid = 1'b0;
        mem_ack = 1'b0;
        chk("t5_pulses", pulses, 32'd1);
        chk("t5_empty", {29'h0, count}, 32'd0);

        // Fence on an empty buffer
        fence_req = 1'b1;
        cycle();
        fence_req = 1'b0;
        chk("t5_empty_done", {31'h0, fence_done}, 32'd1);
        cycle();
        chk("t5_empty_done_end", {31'h0, fence_done}, 32'd0);

        // Asynchronous reset mid-drain
        for (int k = 0; k < 3; k++) store(32'h500 + 32'(k) * 4, 32'hB000_0000 + 32'(k), 4'hF);
        chk("t6_pre_count", {29'h0, count}, 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_req", {31'h0, mem_req}, 32'd0);
        chk("t6_count", {29'h0, count}, 32'd0);
        chk("t6_addr", mem_addr, 32'd0);
        chk("t6_wdata", mem_wdata, 32'd0);
        mb.delete();
        sbq.delete();
        mfence = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        store(32'h600, 32'hC0FFEE00, 4'hF);
        store(32'h604, 32'hC0FFEE04, 4'hF);
        chk("t6_first_after", mem_addr, 32'h600);
        drain();

        // Randomized traffic over a small address window
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom_range(0, 9);
            st_valid  = (r < 4);
            ld_valid  = (r >= 4 && r < 7);
            fence_req = (r == 9) && ($urandom_range(0, 3) == 0);
            st_addr   = 32'h700 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            st_be     = 4'($urandom_range(1, 15));
            ld_addr   = 32'h700 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
            ld_be     = 4'($urandom_range(1, 15));
            mem_ack   = ($urandom_range(0, 2) == 0);
            cycle();
        end
        st_valid = 0; ld_valid = 0; fence_req = 0;
        drain();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
